// File: rtl/shift_reg_checker_if.sv
// Bench-side bundle between a shift-register DUT and its checker: stimulus and
// DUT response flow into the checker, and its verdict flows back out.
interface shift_reg_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             enb;
    logic             dir;
    logic             s_in;
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             s_out;

    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic [WIDTH-1:0] exp_q;
    logic [1:0]       state;

    modport master (
        output enb, dir, s_in, modo, d, q, s_out,
        input  err, err_cnt, chk_cnt, exp_q, state
    );

    modport slave (
        input  enb, dir, s_in, modo, d, q, s_out,
        output err, err_cnt, chk_cnt, exp_q, state
    );
endinterface

// File: rtl/shift_reg_checker.sv
// Golden-model monitor for the shift register: tracks expected Q and counts mismatches.
// Define SHREG_CHK_SOUT_EN to also check the DUT serial output against the model.
module shift_reg_checker #(
    parameter int   WIDTH    = 4,
    parameter int   CNT_W    = 8,
    parameter logic ENB_ACT  = 1'b1,
    parameter int   STOP_ERR = 0
) (
    input logic               clk,
    input logic               rst,
    shift_reg_checker_if.slave bus
);
    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;

    typedef enum logic [1:0] {
        UNSYNC = 2'b00,
        TRACK  = 2'b01,
        FAIL   = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] model, model_next;
    logic             err, err_next;
    logic [CNT_W-1:0] err_cnt, err_cnt_next;
    logic [CNT_W-1:0] chk_cnt, chk_cnt_next;
    logic             mismatch;
    logic             enabled;

`ifdef SHREG_CHK_SOUT_EN
    logic             sout_model, sout_model_next;
`else
    logic             sout_unused;
    assign sout_unused = bus.s_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNSYNC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            model   <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
            chk_cnt <= '0;
`ifdef SHREG_CHK_SOUT_EN
            sout_model <= 1'b0;
`endif
        end else begin
            model   <= model_next;
            err     <= err_next;
            err_cnt <= err_cnt_next;
            chk_cnt <= chk_cnt_next;
`ifdef SHREG_CHK_SOUT_EN
            sout_model <= sout_model_next;
`endif
        end
    end

    // Compare against the pre-edge model first, then advance the model, so a load
    // on a compare edge is checked against the old contents.
    always_comb begin
        state_next   = state;
        model_next   = model;
        err_next     = 1'b0;
        err_cnt_next = err_cnt;
        chk_cnt_next = chk_cnt;
        mismatch     = 1'b0;
        enabled      = (bus.enb == ENB_ACT);
`ifdef SHREG_CHK_SOUT_EN
        sout_model_next = sout_model;
`endif

        if (state == TRACK) begin
            mismatch = (bus.q !== model);
`ifdef SHREG_CHK_SOUT_EN
            mismatch = mismatch | (bus.s_out !== sout_model);
`endif
            if (chk_cnt != '1) chk_cnt_next = chk_cnt + 1'b1;
            if (mismatch) begin
                err_next = 1'b1;
                if (err_cnt != '1) err_cnt_next = err_cnt + 1'b1;
                if (STOP_ERR != 0) state_next = FAIL;
            end
        end

        if (enabled && bus.modo == MODE_LOAD && state == UNSYNC) state_next = TRACK;

        if (enabled) begin
            case (bus.modo)
                MODE_SHIFT:  model_next = bus.dir ? {bus.s_in, model[WIDTH-1:1]}
                                                  : {model[WIDTH-2:0], bus.s_in};
                MODE_ROTATE: model_next = bus.dir ? {model[0], model[WIDTH-1:1]}
                                                  : {model[WIDTH-2:0], model[WIDTH-1]};
                MODE_LOAD:   model_next = bus.d;
                default:     model_next = model;
            endcase
`ifdef SHREG_CHK_SOUT_EN
            case (bus.modo)
                MODE_SHIFT, MODE_ROTATE: sout_model_next = bus.dir ? model[0] : model[WIDTH-1];
                MODE_LOAD:               sout_model_next = 1'b0;
                default:                 sout_model_next = sout_model;
            endcase
`endif
        end
    end

    assign bus.err     = err;
    assign bus.err_cnt = err_cnt;
    assign bus.chk_cnt = chk_cnt;
    assign bus.exp_q   = model;
    assign bus.state   = state;
endmodule
